// File: rtl/cubehash_pkg.sv
// Shared constants, FSM encoding and IV seed for the CubeHash16/32-512 sequencer.
package cubehash_pkg;

  localparam int unsigned CH_ROUNDS     = 16;
  localparam int unsigned CH_FIN_ROUNDS = 160;
  localparam int unsigned CH_HBITS      = 512;
  localparam int unsigned CH_BBYTES     = 32;
  localparam int unsigned CH_STATE_W    = 1024;
  localparam int unsigned CH_MSG_W      = 8 * CH_BBYTES;

  typedef enum logic [2:0] {
    StIdle,
    StIvGen,
    StReady,
    StAbsorb,
    StFinal,
    StDone
  } ch_state_e;

  // x0 = h/8, x1 = b, x2 = r, remaining 29 words zero.
  function automatic logic [CH_STATE_W-1:0] ch_iv_seed(input int unsigned rounds);
    return {32'(CH_HBITS / 8), 32'(CH_BBYTES), 32'(rounds), {(CH_STATE_W - 96){1'b0}}};
  endfunction

endpackage

// File: rtl/CubeHash_ROUND.sv
// One combinational CubeHash round over the 32x32b state; x0 sits in Rin[1023:992].
module CubeHash_ROUND (
  input  logic [1023:0] Rin,
  output logic [1023:0] Rout
);

  function automatic logic [1023:0] round_f(input logic [1023:0] s);
    logic [31:0] x [32];
    logic [31:0] t;
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) x[i] = s[1023-32*i -: 32];
    for (int i = 0; i < 16; i++) begin
      x[i+16] = x[i+16] + x[i];
      x[i]    = {x[i][24:0], x[i][31:25]};
    end
    for (int i = 0; i < 8; i++) begin
      t = x[i]; x[i] = x[i+8]; x[i+8] = t;
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[i+16];
    for (int i = 16; i < 32; i++) begin
      if ((i & 2) == 0) begin
        t = x[i]; x[i] = x[i+2]; x[i+2] = t;
      end
    end
    for (int i = 0; i < 16; i++) begin
      x[i+16] = x[i+16] + x[i];
      x[i]    = {x[i][20:0], x[i][31:21]};
    end
    for (int i = 0; i < 16; i++) begin
      if ((i & 4) == 0) begin
        t = x[i]; x[i] = x[i+4]; x[i+4] = t;
      end
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[i+16];
    for (int i = 16; i < 32; i += 2) begin
      t = x[i]; x[i] = x[i+1]; x[i+1] = t;
    end
    for (int i = 0; i < 32; i++) r[1023-32*i -: 32] = x[i];
    return r;
  endfunction

  assign Rout = round_f(Rin);

endmodule

// File: rtl/cubehash_core_ctrl.sv
// CubeHash16/32-512 sequencer: owns the state register and steps one round per clock.
module cubehash_core_ctrl
  import cubehash_pkg::*;
#(
  parameter int unsigned ROUNDS     = CH_ROUNDS,
  parameter int unsigned FIN_ROUNDS = CH_FIN_ROUNDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [CH_MSG_W-1:0] msg_in,
  input  logic                msg_valid,
  input  logic                msg_last,
  output logic                msg_ready,
  output logic [CH_HBITS-1:0] digest,
  output logic                digest_valid,
  output logic                busy
);

  localparam logic [7:0] LastAbs = 8'(ROUNDS - 1);
  localparam logic [7:0] LastFin = 8'(FIN_ROUNDS - 1);

  logic [CH_STATE_W-1:0] state_q;
  logic [CH_STATE_W-1:0] round_out;
  logic [7:0]            cnt_q;
  logic                  last_q;
  ch_state_e             fsm_q;

  CubeHash_ROUND u_round (
    .Rin  (state_q),
    .Rout (round_out)
  );

  // init overrides everything, including a handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      fsm_q        <= StIdle;
      msg_ready    <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (init) begin
      state_q      <= ch_iv_seed(ROUNDS);
      cnt_q        <= '0;
      last_q       <= 1'b0;
      fsm_q        <= StIvGen;
      msg_ready    <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b1;
    end else begin
      unique case (fsm_q)
        StIvGen: begin
          state_q <= round_out;
          cnt_q   <= cnt_q + 8'd1;
          if (cnt_q == LastFin) begin
            cnt_q     <= '0;
            fsm_q     <= StReady;
            busy      <= 1'b0;
            msg_ready <= 1'b1;
          end
        end
        StReady: begin
          if (msg_valid && msg_ready) begin
            state_q[CH_STATE_W-1 -: CH_MSG_W] <= state_q[CH_STATE_W-1 -: CH_MSG_W] ^ msg_in;
            last_q    <= msg_last;
            cnt_q     <= '0;
            fsm_q     <= StAbsorb;
            msg_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        StAbsorb: begin
          state_q <= round_out;
          cnt_q   <= cnt_q + 8'd1;
          if (cnt_q == LastAbs) begin
            cnt_q <= '0;
            if (last_q) begin
              // Finalization flag: flip the lsb of x31 on the last absorb round's result.
              state_q <= {round_out[CH_STATE_W-1:1], ~round_out[0]};
              fsm_q   <= StFinal;
            end else begin
              fsm_q     <= StReady;
              busy      <= 1'b0;
              msg_ready <= 1'b1;
            end
          end
        end
        StFinal: begin
          state_q <= round_out;
          cnt_q   <= cnt_q + 8'd1;
          if (cnt_q == LastFin) begin
            cnt_q        <= '0;
            fsm_q        <= StDone;
            busy         <= 1'b0;
            digest       <= round_out[CH_STATE_W-1 -: CH_HBITS];
            digest_valid <= 1'b1;
          end
        end
        StIdle, StDone: ;
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule
